// File: rtl/disaster_alert_ctrl.sv
// Alert sequencer for the four-hazard detector: debounced confirm, latch until ack+clear, blink/buzzer/priority.
// Optional escalation timer is built when ALERT_ESCALATE_EN is defined.
module disaster_alert_ctrl #(
  parameter int unsigned SAMPLE_DIV  = 1000,
  parameter int unsigned PERSIST     = 4,
  parameter int unsigned BLINK_TICKS = 8,
  parameter int unsigned ESC_TICKS   = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] det,
  input  logic       ack,
  output logic [3:0] led,
  output logic       buzzer,
  output logic       top_valid,
  output logic [1:0] top_code,
  output logic [1:0] state,
  output logic       escalate
);

  localparam int unsigned NH    = 4;
  localparam int unsigned DIV_W = $clog2(SAMPLE_DIV);
  localparam int unsigned CNT_W = 4;
  localparam int unsigned BLK_W = $clog2(BLINK_TICKS + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ALARM   = 2'd1,
    S_ACKED   = 2'd2,
    S_RECOVER = 2'd3
  } state_e;

  logic [NH-1:0]    det_meta;
  logic [NH-1:0]    ds;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [CNT_W-1:0] on_cnt  [NH];
  logic [CNT_W-1:0] off_cnt [NH];
  logic [CNT_W-1:0] on_nxt  [NH];
  logic [CNT_W-1:0] off_nxt [NH];
  logic [NH-1:0]    confirm_c;
  logic [NH-1:0]    latched;
  logic [NH-1:0]    unacked;
  logic [NH-1:0]    latched_nxt;
  logic [NH-1:0]    unacked_nxt;
  state_e           state_q;
  state_e           state_nxt;
  logic             phase;
  logic             phase_nxt;
  logic [BLK_W-1:0] blink_cnt;
  logic [BLK_W-1:0] blink_nxt;
  logic [NH-1:0]    led_nxt;
  logic [1:0]       top_code_nxt;

  assign tick  = (div_cnt == DIV_W'(SAMPLE_DIV - 1));
  assign state = state_q;

  // Synchronizer, sample divider and per-hazard persistence/latch registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      det_meta <= '0;
      ds       <= '0;
      div_cnt  <= '0;
      latched  <= '0;
      unacked  <= '0;
      for (int i = 0; i < NH; i++) begin
        on_cnt[i]  <= '0;
        off_cnt[i] <= '0;
      end
    end else begin
      det_meta <= det;
      ds       <= det_meta;
      div_cnt  <= tick ? '0 : div_cnt + DIV_W'(1);
      latched  <= latched_nxt;
      unacked  <= unacked_nxt;
      for (int i = 0; i < NH; i++) begin
        on_cnt[i]  <= on_nxt[i];
        off_cnt[i] <= off_nxt[i];
      end
    end
  end

  // Persistence counting, confirm detection, ack and clear; a same-cycle confirm survives ack
  always_comb begin
    confirm_c = '0;
    for (int i = 0; i < NH; i++) begin
      on_nxt[i]  = on_cnt[i];
      off_nxt[i] = off_cnt[i];
      if (tick) begin
        if (ds[i]) begin
          on_nxt[i]    = (on_cnt[i] == CNT_W'(PERSIST)) ? on_cnt[i] : on_cnt[i] + CNT_W'(1);
          off_nxt[i]   = '0;
          confirm_c[i] = (on_cnt[i] == CNT_W'(PERSIST - 1));
        end else begin
          off_nxt[i] = (off_cnt[i] == CNT_W'(PERSIST)) ? off_cnt[i] : off_cnt[i] + CNT_W'(1);
          on_nxt[i]  = '0;
        end
      end
    end
    unacked_nxt = (ack ? '0 : unacked) | confirm_c;
    for (int i = 0; i < NH; i++) begin
      latched_nxt[i] = (latched[i] | confirm_c[i]) &
                       ~((off_nxt[i] == CNT_W'(PERSIST)) & ~unacked_nxt[i]);
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_nxt;
  end

  // FSM next state from the post-update alarm sets
  always_comb begin
    state_nxt = S_IDLE;
    if (|unacked_nxt)                                           state_nxt = S_ALARM;
    else if ((latched_nxt != '0) && ((latched_nxt & ~ds) == '0)) state_nxt = S_ACKED;
    else if (latched_nxt != '0)                                 state_nxt = S_RECOVER;
  end

  // Output next values: blink phase, LED mux and priority encoder
  always_comb begin
    phase_nxt = 1'b0;
    blink_nxt = '0;
    if (state_nxt == S_ALARM) begin
      if (state_q != S_ALARM) begin
        phase_nxt = 1'b1;
      end else begin
        phase_nxt = phase;
        blink_nxt = blink_cnt;
        if (tick) begin
          if (blink_cnt == BLK_W'(BLINK_TICKS - 1)) begin
            phase_nxt = ~phase;
            blink_nxt = '0;
          end else begin
            blink_nxt = blink_cnt + BLK_W'(1);
          end
        end
      end
    end
    for (int i = 0; i < NH; i++) begin
      led_nxt[i] = unacked_nxt[i] ? phase_nxt : latched_nxt[i];
    end
    top_code_nxt = 2'd0;
    for (int i = 0; i < NH; i++) begin
      if (latched_nxt[i]) top_code_nxt = 2'(i);
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase     <= 1'b0;
      blink_cnt <= '0;
      led       <= '0;
      buzzer    <= 1'b0;
      top_valid <= 1'b0;
      top_code  <= '0;
    end else begin
      phase     <= phase_nxt;
      blink_cnt <= blink_nxt;
      led       <= led_nxt;
      buzzer    <= |unacked_nxt;
      top_valid <= |latched_nxt;
      top_code  <= top_code_nxt;
    end
  end

`ifdef ALERT_ESCALATE_EN
  localparam int unsigned ESC_W = $clog2(ESC_TICKS + 1);

  logic [ESC_W-1:0] esc_cnt;

  // Count ticks while the buzzer sounds; hold escalate until the next ack
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      esc_cnt  <= '0;
      escalate <= 1'b0;
    end else if (ack) begin
      esc_cnt  <= '0;
      escalate <= 1'b0;
    end else if (tick && buzzer && (esc_cnt != ESC_W'(ESC_TICKS))) begin
      esc_cnt <= esc_cnt + ESC_W'(1);
      if (esc_cnt == ESC_W'(ESC_TICKS - 1)) escalate <= 1'b1;
    end
  end
`else
  // Constant 0; still references ESC_TICKS so the parameter stays live in this build
  localparam logic ESC_OFF = 1'b0 & (ESC_TICKS != 0);

  assign escalate = ESC_OFF;
`endif

endmodule

// File: tb/tb_disaster_alert_ctrl.sv
// Randomized and directed bench for disaster_alert_ctrl against a run-length behavioural model.
module tb_disaster_alert_ctrl;

  localparam int SAMPLE_DIV  = 4;
  localparam int PERSIST     = 3;
  localparam int BLINK_TICKS = 2;
  localparam int ESC_TICKS   = 5;
`ifdef ALERT_ESCALATE_EN
  localparam logic ESC_BUILT = 1'b1;
`else
  localparam logic ESC_BUILT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] det = 4'd0;
  logic       ack = 1'b0;
  logic [3:0] led;
  logic       buzzer, top_valid, escalate;
  logic [1:0] top_code, state;
  logic [10:0] dut_vec;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  disaster_alert_ctrl #(
    .SAMPLE_DIV(SAMPLE_DIV), .PERSIST(PERSIST), .BLINK_TICKS(BLINK_TICKS), .ESC_TICKS(ESC_TICKS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .det(det), .ack(ack), .led(led), .buzzer(buzzer),
    .top_valid(top_valid), .top_code(top_code), .state(state), .escalate(escalate)
  );

  assign dut_vec = {led, buzzer, top_valid, top_code, state, escalate};

  // Reference model: edge counts, run lengths of sampled levels and hazard sets
  int         m_div;
  logic [3:0] m_meta, m_ds;
  int         hi_run [4];
  int         lo_run [4];
  logic [3:0] m_lat, m_unack;
  int         m_state;
  int         alarm_ticks;
  int         esc_n;
  logic       m_esc, m_buz;
  logic [10:0] exp_vec;

  function automatic void model_edge();
    logic       t;
    logic [3:0] conf;
    logic [3:0] led_e;
    logic [1:0] tc;
    logic       ph;
    int         ns;
    if (!rst_n) begin
      m_div = 0; m_meta = 0; m_ds = 0; m_lat = 0; m_unack = 0; m_state = 0;
      alarm_ticks = 0; esc_n = 0; m_esc = 0; m_buz = 0; exp_vec = 0;
      for (int i = 0; i < 4; i++) begin hi_run[i] = 0; lo_run[i] = 0; end
      return;
    end
    t = (m_div == SAMPLE_DIV - 1);
    conf = 0;
    if (t) begin
      for (int i = 0; i < 4; i++) begin
        if (m_ds[i]) begin
          hi_run[i]++; lo_run[i] = 0;
          if (hi_run[i] == PERSIST) conf[i] = 1'b1;
        end else begin
          lo_run[i]++; hi_run[i] = 0;
        end
      end
    end
    m_unack = (ack ? 4'd0 : m_unack) | conf;
    m_lat   = m_lat | conf;
    for (int i = 0; i < 4; i++)
      if (lo_run[i] >= PERSIST && !m_unack[i]) m_lat[i] = 1'b0;
    if (m_unack != 0)                           ns = 1;
    else if (m_lat != 0 && (m_lat & ~m_ds) == 0) ns = 2;
    else if (m_lat != 0)                        ns = 3;
    else                                        ns = 0;
    if (ns != 1 || m_state != 1) alarm_ticks = 0;
    else if (t)                  alarm_ticks++;
    ph = (ns == 1) && ((alarm_ticks / BLINK_TICKS) % 2 == 0);
    if (ESC_BUILT) begin
      if (ack) begin esc_n = 0; m_esc = 0; end
      else if (t && m_buz && esc_n < ESC_TICKS) begin
        esc_n++;
        if (esc_n == ESC_TICKS) m_esc = 1;
      end
    end
    m_state = ns;
    m_ds    = m_meta;
    m_meta  = det;
    m_div   = (m_div + 1) % SAMPLE_DIV;
    m_buz   = (m_unack != 0);
    for (int i = 0; i < 4; i++) led_e[i] = m_unack[i] ? ph : m_lat[i];
    tc = 0;
    for (int i = 0; i < 4; i++) if (m_lat[i]) tc = 2'(i);
    exp_vec = {led_e, m_buz, (m_lat != 0), tc, 2'(ns), m_esc};
  endfunction

  function automatic bit eq_confirms_next();
    return (m_div == SAMPLE_DIV - 1) && m_ds[2] && (hi_run[2] == PERSIST - 1);
  endfunction

  task automatic cyc(input logic [3:0] d, input logic a);
    det = d;
    ack = a;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) cyc(4'($urandom), 1'($urandom));
    total++;
    if (dut_vec !== 11'd0) begin bad++; $display("FAIL reset: got %b need 0", dut_vec); end
    rst_n = 1'b1;
  endtask

  task automatic test_persistence();
    bit seen;
    int blink_err;
    for (int k = 0; k < 24; k++) begin
      cyc((k < 8) ? 4'b0001 : 4'b0000, 1'b0);
      total++;
      if (dut_vec !== exp_vec) begin bad++; $display("FAIL persist_short t=%0t got %b exp %b", $time, dut_vec, exp_vec); end
    end
    total++;
    if (state !== 2'd0 || buzzer !== 1'b0) begin bad++; $display("FAIL persist_no_alarm: state=%0d buzzer=%b need 0/0", state, buzzer); end
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      cyc(4'b0001, 1'b0);
      total++;
      if (dut_vec !== exp_vec) begin bad++; $display("FAIL persist_cyc t=%0t got %b exp %b", $time, dut_vec, exp_vec); end
      seen = (buzzer === 1'b1);
    end
    total++;
    if (!seen || state !== 2'd1 || top_code !== 2'd0 || top_valid !== 1'b1) begin
      bad++; $display("FAIL persist_confirm: buzzer=%b state=%0d code=%0d valid=%b need 1/1/0/1", buzzer, state, top_code, top_valid);
    end
    blink_err = 0;
    for (int j = 0; j < 32; j++) begin
      if (j > 0) begin
        cyc(4'b0001, 1'b0);
        total++;
        if (dut_vec !== exp_vec) begin bad++; $display("FAIL blink_cyc t=%0t got %b exp %b", $time, dut_vec, exp_vec); end
      end
      if (led[0] !== ((j / 8) % 2 == 0)) blink_err++;
    end
    total++;
    if (blink_err != 0) begin bad++; $display("FAIL blink_period: %0d wrong samples need 0", blink_err); end
  endtask

  task automatic test_priority_ack();
    bit seen;
    int err;
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      cyc(4'b1001, 1'b0);
      total++;
      if (dut_vec !== exp_vec) begin bad++; $display("FAIL prio_cyc t=%0t got %b exp %b", $time, dut_vec, exp_vec); end
      seen = (top_code === 2'd3);
    end
    total++;
    if (!seen || buzzer !== 1'b1) begin bad++; $display("FAIL priority: code=%0d buzzer=%b need 3/1", top_code, buzzer); end
    cyc(4'b1001, 1'b1);
    total++;
    if (buzzer !== 1'b0 || state !== 2'd2 || led !== 4'b1001) begin
      bad++; $display("FAIL ack: buzzer=%b state=%0d led=%b need 0/2/1001", buzzer, state, led);
    end
    err = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(4'b1001, 1'b0);
      total++;
      if (dut_vec !== exp_vec) begin bad++; $display("FAIL acked_cyc t=%0t got %b exp %b", $time, dut_vec, exp_vec); end
      if (led !== 4'b1001) err++;
    end
    total++;
    if (err != 0) begin bad++; $display("FAIL ack_steady: %0d cycles led not 1001", err); end
  endtask

  task automatic test_ack_race();
    bit seen;
    int err;
    rst_n = 1'b0;
    cyc(4'b0000, 1'b0);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      cyc(4'b0001, 1'b0);
      total++;
      if (dut_vec !== exp_vec) begin bad++; $display("FAIL race_pre t=%0t got %b exp %b", $time, dut_vec, exp_vec); end
      seen = (buzzer === 1'b1);
    end
    seen = 0;
    for (int k = 0; k < 80 && !seen; k++) begin
      seen = eq_confirms_next();
      if (!seen) begin
        cyc(4'b0101, 1'b0);
        total++;
        if (dut_vec !== exp_vec) begin bad++; $display("FAIL race_wait t=%0t got %b exp %b", $time, dut_vec, exp_vec); end
      end
    end
    total++;
    if (!seen) begin bad++; $display("FAIL race_timeout: confirm edge not reached need reached"); end
    cyc(4'b0101, 1'b1);
    total++;
    if (buzzer !== 1'b1 || state !== 2'd1 || top_code !== 2'd2) begin
      bad++; $display("FAIL ack_race: buzzer=%b state=%0d code=%0d need 1/1/2", buzzer, state, top_code);
    end
    err = 0;
    for (int k = 0; k < 16; k++) begin
      cyc(4'b0101, 1'b0);
      total++;
      if (dut_vec !== exp_vec) begin bad++; $display("FAIL race_cyc t=%0t got %b exp %b", $time, dut_vec, exp_vec); end
      if (led[0] !== 1'b1) err++;
    end
    total++;
    if (err != 0) begin bad++; $display("FAIL race_flood_acked: %0d cycles led0 low need 0", err); end
  endtask

  task automatic test_clear();
    bit seen, saw_rec;
    cyc(4'b0101, 1'b1);
    total++;
    if (buzzer !== 1'b0 || state !== 2'd2) begin bad++; $display("FAIL clear_ack: buzzer=%b state=%0d need 0/2", buzzer, state); end
    seen = 0; saw_rec = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      cyc(4'b0000, 1'b0);
      total++;
      if (dut_vec !== exp_vec) begin bad++; $display("FAIL clear_cyc t=%0t got %b exp %b", $time, dut_vec, exp_vec); end
      if (state === 2'd3) saw_rec = 1;
      seen = (state === 2'd0);
    end
    total++;
    if (!saw_rec || !seen || led !== 4'd0 || top_valid !== 1'b0) begin
      bad++; $display("FAIL clear: recover=%0d idle=%0d led=%b valid=%b need 1/1/0000/0", saw_rec, seen, led, top_valid);
    end
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      cyc(4'b0010, 1'b0);
      total++;
      if (dut_vec !== exp_vec) begin bad++; $display("FAIL sticky_pre t=%0t got %b exp %b", $time, dut_vec, exp_vec); end
      seen = (buzzer === 1'b1);
    end
    for (int k = 0; k < 44; k++) begin
      cyc(4'b0000, 1'b0);
      total++;
      if (dut_vec !== exp_vec) begin bad++; $display("FAIL sticky_cyc t=%0t got %b exp %b", $time, dut_vec, exp_vec); end
    end
    total++;
    if (top_valid !== 1'b1 || buzzer !== 1'b1 || state !== 2'd1) begin
      bad++; $display("FAIL unacked_sticky: valid=%b buzzer=%b state=%0d need 1/1/1", top_valid, buzzer, state);
    end
  endtask

  task automatic test_reset_mid_alarm();
    bit seen;
    int n;
    rst_n = 1'b0;
    cyc(4'b0010, 1'b0);
    rst_n = 1'b1;
    total++;
    if (dut_vec !== 11'd0) begin bad++; $display("FAIL reset_mid: got %b need 0", dut_vec); end
    seen = 0; n = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      cyc(4'b0010, 1'b0);
      n++;
      total++;
      if (dut_vec !== exp_vec) begin bad++; $display("FAIL reconfirm_cyc t=%0t got %b exp %b", $time, dut_vec, exp_vec); end
      seen = (buzzer === 1'b1);
    end
    total++;
    if (!seen || n != 12) begin bad++; $display("FAIL reconfirm_latency: seen=%0d edges=%0d need 1/12", seen, n); end
  endtask

  task automatic test_escalate();
    for (int k = 0; k < 48; k++) begin
      cyc(4'b0010, 1'b0);
      total++;
      if (dut_vec !== exp_vec) begin bad++; $display("FAIL esc_cyc t=%0t got %b exp %b", $time, dut_vec, exp_vec); end
    end
    total++;
    if (escalate !== ESC_BUILT) begin bad++; $display("FAIL escalate: got %b need %b", escalate, ESC_BUILT); end
    cyc(4'b0010, 1'b1);
    total++;
    if (escalate !== 1'b0 || buzzer !== 1'b0) begin bad++; $display("FAIL esc_ack: esc=%b buzzer=%b need 0/0", escalate, buzzer); end
  endtask

  task automatic test_random();
    int         hold;
    logic [3:0] d;
    hold = 0; d = 0;
    for (int k = 0; k < 2500; k++) begin
      if (hold == 0) begin d = 4'($urandom); hold = $urandom_range(1, 24); end
      hold--;
      if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
      cyc(d, 1'($urandom_range(0, 15) == 0));
      rst_n = 1'b1;
      total++;
      if (dut_vec !== exp_vec) begin bad++; $display("FAIL random_cyc t=%0t got %b exp %b", $time, dut_vec, exp_vec); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_persistence();
    test_priority_ack();
    test_ack_race();
    test_clear();
    test_reset_mid_alarm();
    test_escalate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/disaster_alert_ctrl.md
Name: disaster_alert_ctrl

Overview:
- Alert sequencer downstream of the four-hazard disaster detector, which runs in per-hazard (mode=1) output.
- Samples the raw hazard flags on a periodic tick and requires a persistence count before confirming a hazard.
- Latches confirmed alarms until an operator acknowledges them and the hazard has cleared.
- Drives blink/steady LEDs, a buzzer and a priority code for the display.

Parameters:
- SAMPLE_DIV, 1000, clocks per sample tick (>=2).
- PERSIST, 4, consecutive samples needed to confirm, and to clear (1..15).
- BLINK_TICKS, 8, sample ticks per blink half-period (>=1).
- ESC_TICKS, 64, sample ticks before escalation; used only with ALERT_ESCALATE_EN.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- det  in  4  raw hazard flags {tsunami, earthquake, cyclone, flood}; asynchronous to clk.
- ack  in  1  single-cycle acknowledge pulse, synchronous to clk.
- led  out  4  per-hazard indicator, same bit order as det.
- buzzer  out  1  high while any alarm is unacknowledged.
- top_valid  out  1  any hazard latched.
- top_code  out  2  highest-priority latched hazard: 3=tsunami, 2=earthquake, 1=cyclone, 0=flood.
- state  out  2  0=IDLE, 1=ALARM, 2=ACKED, 3=RECOVER.
- escalate  out  1  escalation flag; constant 0 without the macro.

Behaviour:
- Reset: one clock and reset as above; reset is synchronous and active-low. While rst_n=0 at a clk edge:
  - All registers clear: synchronizers, divider, counters, latched, unacked, blink phase.
  - All outputs 0; state=IDLE.
  - Reset mid-alarm discards all alarms.
- Input sync: det passes through a 2-flop synchronizer (ds). ack is used directly.
- Sample tick: the divider counts 0..SAMPLE_DIV-1 and wraps. tick=1 for one clk when the divider equals SAMPLE_DIV-1.
- Per hazard i, on each tick:
  - ds[i]=1: on_cnt[i] increments, saturating at PERSIST; off_cnt[i] is set to 0.
  - ds[i]=0: off_cnt[i] increments, saturating at PERSIST; on_cnt[i] is set to 0.
- Confirm: on the tick where on_cnt[i] goes PERSIST-1 -> PERSIST, latched[i] and unacked[i] are set. They are visible the next cycle.
- Ack: an ack in a cycle clears every unacked bit that was set before that cycle. A confirm in the same cycle as ack stays unacked.
- Clear: latched[i] clears when off_cnt[i]==PERSIST and unacked[i]==0.
  - An unacknowledged alarm never self-clears, even if det drops.
- FSM (registered; priority is top to bottom):
  - any unacked (including same-cycle new confirm) -> ALARM.
  - else latched!=0 and every latched hazard has ds=1 -> ACKED.
  - else latched!=0 -> RECOVER.
  - else -> IDLE.
- Blink:
  - Phase toggles every BLINK_TICKS ticks while state==ALARM.
  - Phase is forced to 1 when entering ALARM from any other state.
  - Phase holds at 0 outside ALARM.
- Outputs (registered):
  - led[i] = unacked[i] ? phase : latched[i].
  - buzzer = |unacked.
  - top_valid = |latched.
  - top_code = index of the highest set latched bit; 0 when none is set.
- Latency: det edge -> ds takes 2 clk. Confirm needs PERSIST ticks of high ds, and led/buzzer update 1 clk after the confirming tick.
- Ack with nothing unacked has no effect.

Optional Feature:
- Macro: ALERT_ESCALATE_EN.
- Defined:
  - An esc_cnt counts ticks while buzzer=1.
  - When esc_cnt reaches ESC_TICKS, escalate=1 and is held.
  - Any ack clears both escalate and esc_cnt. A new confirm restarts the count only if esc_cnt was idle.
- Undefined: no esc_cnt logic; escalate is tied to 0; ESC_TICKS is ignored.

Test Plan:
- Bench parameters for all scenarios: SAMPLE_DIV=4, PERSIST=3, BLINK_TICKS=2.
- Persistence: det=4'b0001 high for 2 ticks, then low -> no alarm; state stays 0. Held high for 3 ticks -> next cycle buzzer=1, state=1, top_code=0, led[0] blinks with period 16 clk.
- Priority plus ack: flood and tsunami both confirmed -> top_code=3. ack pulse -> buzzer=0, state=2, led=4'b1001 steady.
- Ack race: earthquake confirms in the same cycle as ack, while flood is unacked -> flood acked; earthquake stays unacked; buzzer=1; state=1.
- Clear: acked flood, then det=0 for 3 ticks -> RECOVER during the wait, then latched clears and state=0, led=0, top_valid=0. An unacked hazard with det=0 for 10 ticks stays latched.
- Reset mid-alarm: rst_n=0 for 1 clk while in ALARM -> all outputs 0 next cycle. With det still high, re-confirm takes a full 3 ticks.
- ALERT_ESCALATE_EN, ESC_TICKS=5: leave an alarm unacked -> escalate=1 after 5 ticks; ack -> escalate=0 next cycle. Without the macro, escalate=0 throughout.
